// File: rtl/alu_exec_stage.sv
// ALU execute stage: combinational ALU, registered result/flags, architectural flag register.
// Define ALU_EXEC_SKID_EN for a one-entry input skid buffer (registered in_ready).
module alu_exec_alu #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [2:0]      op,
  output logic [SIZE-1:0] result,
  output logic            carry,
  output logic            ovf
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_NOT = 3'b101,
                         OP_PSB = 3'b110;

  logic [SIZE-1:0] b_eff;
  logic [SIZE:0]   sum;
  logic            cin;

  always_comb begin
    cin    = (op == OP_SUB);
    b_eff  = cin ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{SIZE{1'b0}}, cin};
    carry  = sum[SIZE];
    ovf    = (a[SIZE-1] == b_eff[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);
    result = '0;
    case (op)
      OP_ADD, OP_SUB: result = sum[SIZE-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_PSB:         result = b;
      default:        result = '0;
    endcase
  end
endmodule

module alu_exec_stage #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [SIZE-1:0] in_b,
  input  logic [2:0]      in_op,
  input  logic            in_flag_write,
  input  logic [3:0]      in_dest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_result,
  output logic [3:0]      out_flags,
  output logic [3:0]      out_dest,
  output logic            out_err,
  output logic [3:0]      flags_q
);
  typedef struct packed {
    logic [SIZE-1:0] result;
    logic [3:0]      flags;
    logic [3:0]      dest;
    logic            err;
  } payload_t;

  logic [SIZE-1:0] alu_res;
  logic            alu_c, alu_v;
  logic            is_arith, is_err, accept, transfer_out, out_free;
  payload_t        new_p, out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      arch_flags_q, arch_flags_d;

  alu_exec_alu #(.SIZE(SIZE)) u_alu (
    .a(in_a), .b(in_b), .op(in_op), .result(alu_res), .carry(alu_c), .ovf(alu_v)
  );

  // Flags are resolved at acceptance so a skid-held op keeps the flags_q it saw then.
  always_comb begin
    is_arith     = (in_op == 3'b000) || (in_op == 3'b001);
    is_err       = (in_op == 3'b111);
    new_p.dest   = in_dest;
    new_p.err    = is_err;
    new_p.result = is_err ? '0 : alu_res;
    new_p.flags  = is_err ? arch_flags_q :
                   {alu_res[SIZE-1], (alu_res == '0),
                    is_arith ? alu_c : arch_flags_q[1],
                    is_arith ? alu_v : arch_flags_q[0]};
  end

  assign transfer_out = out_valid_q && out_ready;
  assign out_free     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;

`ifdef ALU_EXEC_SKID_EN
  payload_t skid_q, skid_d;
  logic     skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q && !reset;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (out_free) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_d       = new_p;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_p;
        skid_valid_d = 1'b1;
      end
    end else if (transfer_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  assign in_ready = (!out_valid_q || out_ready) && !reset;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (accept) begin
      out_d       = new_p;
      out_valid_d = 1'b1;
    end else if (transfer_out) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    arch_flags_d = arch_flags_q;
    if (accept && in_flag_write && !is_err) arch_flags_d = new_p.flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      arch_flags_q <= 4'b0000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      arch_flags_q <= arch_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_q.result;
  assign out_flags  = out_q.flags;
  assign out_dest   = out_q.dest;
  assign out_err    = out_q.err;
  assign flags_q    = arch_flags_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage; expected results come from an integer reference model.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_flag_write, out_valid, out_ready, out_err;
  logic [15:0] in_a, in_b, out_result;
  logic [2:0]  in_op;
  logic [3:0]  in_dest, out_flags, out_dest, flags_q;

  always #5 clk = ~clk;

  alu_exec_stage #(.SIZE(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_flag_write(in_flag_write),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_dest(out_dest),
    .out_err(out_err), .flags_q(flags_q)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  dest;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op, input logic [3:0] dest,
                                 input logic [3:0] fl);
    exp_t m;
    int ua, ub, sa, sbv, s, sd;
    logic [15:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    c = fl[1]; v = fl[0]; r = 16'h0; s = 0; sd = 0;
    case (op)
      3'd0: begin s = ua + ub; r = s[15:0]; c = (s > 65535);
                  sd = sa + sbv; v = (sd > 32767) || (sd < -32768); end
      3'd1: begin s = ua + (65535 - ub) + 1; r = s[15:0]; c = (s > 65535);
                  sd = sa - sbv; v = (sd > 32767) || (sd < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = b;
      default: r = 16'h0;
    endcase
    m.dest = dest;
    if (op == 3'd7) begin
      m.res = 16'h0; m.fl = fl; m.err = 1'b1;
    end else begin
      m.res = r; m.fl = {r[15], (r == 16'h0), c, v}; m.err = 1'b0;
    end
    return m;
  endfunction

  // Drive one cycle of stimulus; score handshakes at the negedge, flags_q after the edge.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic fw, input logic [3:0] dest,
                       input logic ordy);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_flag_write = fw;
    in_dest = dest; out_ready = ordy;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("result", out_result, e.res);
        check_eq("flags", out_flags, e.fl);
        check_eq("dest", out_dest, e.dest);
        check_eq("err", out_err, e.err);
        $display("out dest=%0h result=%04h flags=%04b err=%0b", out_dest, out_result, out_flags, out_err);
      end
    end else if (out_valid && sb.size() != 0) begin
      check_eq("stall_result", out_result, sb[0].res);
      check_eq("stall_dest", out_dest, sb[0].dest);
    end
    if (in_valid && in_ready) begin
      e = model(a, b, op, dest, mflags);
      sb.push_back(e);
      acc_cnt++;
      if (fw && op != 3'd7) mflags = e.fl;
    end
    @(posedge clk);
    #1;
    check_eq("flags_q", flags_q, mflags);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 1'b1);
      k++;
    end
    check_eq("drain_empty", sb.size(), 0);
    cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; mflags = 4'h0;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_flag_write = 0; in_dest = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_flags_q", flags_q, 0);
    check_eq("rst_out_result", out_result, 0);
    reset = 1'b0;
    #1;
    check_eq("in_ready_after_rst", in_ready, 1);

    cycle(1, 16'h7FFF, 16'h0001, 3'd0, 1, 4'h1, 1);
    check_eq("add_ovf_res", out_result, 16'h8000);
    check_eq("add_ovf_flags", out_flags, 4'b1001);
    cycle(1, 16'h0005, 16'h0005, 3'd1, 1, 4'h2, 1);
    check_eq("sub_zero_res", out_result, 16'h0000);
    check_eq("sub_zero_flags", out_flags, 4'b0110);
    check_eq("sub_zero_flags_q", flags_q, 4'b0110);
    cycle(1, 16'hFFFF, 16'h0001, 3'd0, 1, 4'h3, 1);
    cycle(1, 16'h00F0, 16'h0F00, 3'd2, 1, 4'h4, 1);
    check_eq("and_keep_c", out_flags, 4'b0110);
    check_eq("and_flags_q", flags_q, 4'b0110);
    cycle(1, 16'h8000, 16'h0000, 3'd0, 1, 4'h5, 1);
    cycle(1, 16'h1234, 16'h0000, 3'd7, 1, 4'h6, 1);
    check_eq("ill_res", out_result, 16'h0000);
    check_eq("ill_err", out_err, 1);
    check_eq("ill_flags", out_flags, 4'b1000);
    check_eq("ill_flags_q", flags_q, 4'b1000);
    drain();

    acc_cnt = 0;
    for (int i = 0; i < 3; i++)
      cycle(1, 16'(16'h0100 + i), 16'h0011, 3'd4, 1, 4'(8 + i), 0);
`ifdef ALU_EXEC_SKID_EN
    check_eq("stall_accepts", acc_cnt, 2);
`else
    check_eq("stall_accepts", acc_cnt, 1);
`endif
    drain();

    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) != 0));
    drain();

    cycle(1, 16'hFFFF, 16'hFFFF, 3'd0, 1, 4'hA, 0);
    cycle(1, 16'h0001, 16'h0002, 3'd3, 1, 4'hB, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_flags_q", flags_q, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_out_dest", out_dest, 0);
    sb.delete();
    mflags = 4'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 16'h0, 3'd0, 0, 4'h0, 1);
    check_eq("post_rst_idle", out_valid, 0);
    cycle(1, 16'h0003, 16'h0004, 3'd0, 1, 4'hC, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter SIZE, default 16, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 in_a, in_b  input  SIZE each  operands.
REQ-007 in_op  input  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 pass b, 111 illegal.
REQ-008 in_flag_write  input  1  commit this op's flags to the architectural flag register.
REQ-009 in_dest  input  4  destination register tag, carried through unchanged.
REQ-010 out_valid  output  1  registered result valid.
REQ-011 out_ready  input  1  downstream (writeback) accepts result.
REQ-012 out_result  output  SIZE  registered ALU result.
REQ-013 out_flags  output  4  registered per-op flags {N,Z,C,V}.
REQ-014 out_dest  output  4  registered destination tag.
REQ-015 out_err  output  1  registered; 1 when the op was 111.
REQ-016 flags_q  output  4  architectural flag register {N,Z,C,V}.

Function
REQ-017 The stage SHALL instantiate the team ALU (SIZE-wide) combinationally on in_a/in_b/in_op; the result is registered, giving 1-cycle latency from acceptance to out_valid.
REQ-018 Accept = in_valid && in_ready; transfer out = out_valid && out_ready; in_valid may drop without acceptance.
REQ-019 Flags: N=result[SIZE-1], Z=(result==0), C=adder carry-out, V=signed overflow; SUB computes a+~b+1.
REQ-020 For ops 010-110, out_flags C,V SHALL equal flags_q C,V at acceptance; only N,Z are derived from the result.
REQ-021 Op 111: out_result=0, out_flags=flags_q, out_err=1, flags_q unchanged even if in_flag_write=1.
REQ-022 flags_q SHALL update on the accept edge when in_flag_write=1 and op is not 111, so back-to-back ops see the predecessor's flags with no bubble.
REQ-023 Output register SHALL hold result, flags, dest, err stable while out_valid && !out_ready.
REQ-024 Transactions SHALL leave in acceptance order; none dropped or duplicated.
REQ-025 Simultaneous transfer-out and accept in one cycle SHALL sustain throughput of 1 op/cycle.

Reset
REQ-026 On reset assertion, immediately: out_valid=0, out_result=0, out_flags=0, out_dest=0, out_err=0, flags_q=0, skid buffer empty.
REQ-027 in_ready SHALL be 0 while reset is high and 1 on the first cycle after release.
REQ-028 A transaction in flight at reset assertion SHALL be discarded without reaching the output.

Configuration
REQ-029 Macro ALU_EXEC_SKID_EN selects a one-entry skid buffer on the input side.
REQ-030 With ALU_EXEC_SKID_EN defined: in_ready SHALL be a register output (= skid empty); a request accepted while the output is stalled is stored in the skid entry and moves to the output register on the next transfer-out; no combinational path from out_ready to in_ready.
REQ-031 Without ALU_EXEC_SKID_EN: in_ready SHALL be combinational = !out_valid || out_ready; no skid storage.
REQ-032 Both builds SHALL present identical transaction order, values and flags_q sequence.

Verification
REQ-033 ADD 0x7FFF+0x0001, flag_write=1 -> next cycle out_result=0x8000, out_flags=1001, flags_q=1001.
REQ-034 SUB 0x0005-0x0005, flag_write=1 -> out_result=0x0000, out_flags=0110, flags_q=0110.
REQ-035 ADD 0xFFFF+0x0001 (flags_q=0110) then AND 0x00F0&0x0F00, flag_write=1 -> AND out_flags=0110 (C retained), flags_q=0110.
REQ-036 Hold out_ready=0 for 3 cycles with 3 requests offered -> out_result stable; skid build accepts exactly 2, no-skid build 1; after release all appear in order with no loss.
REQ-037 Op 111, a=0x1234, flag_write=1, flags_q=1000 -> out_result=0x0000, out_err=1, out_flags=1000, flags_q unchanged.
REQ-038 Assert reset mid-cycle with out_valid=1 -> out_valid and flags_q drop to 0 before the next clk edge; held request never emitted.
